// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and queue-entry helpers for the fetch stage.
// Holds default widths, the reset PC, the default-width entry layout and
// a helper that gives the packed entry width for any parameterisation.
package fetch_pkg;
    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int PC_STEP_DEF = 2;
    localparam int DEPTH_DEF   = 4;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    // Entry layout: instruction in the upper bits, next-PC in the lower bits.
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc_next;
    } entry_t;

    function automatic int entry_w(input int instr_w, input int addr_w);
        return instr_w + addr_w;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of DEPTH entries with a combinational head read.
// Ports: clock, reset (sync, active-high), clear (drops all entries),
//        push/wdata (enqueue), pop (dequeue head), head (current head entry),
//        count (occupancy after the edge).
// The caller never pushes into a full queue unless it pops in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int W     = entry_w(INSTR_W_DEF, ADDR_W_DEF),
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr, wptr;

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction request logic and prefetch queue feeding decode.
// Ports: clock, reset (sync, active-high);
//        imem_addr/imem_req/imem_ready/imem_rdata (instruction memory handshake);
//        redirect/redirect_addr (flush and reload PC), halt (stop new fetches);
//        out_valid/out_instr/out_pc_next/out_ready (decode handshake);
//        count (queue occupancy).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int EW     = entry_w(INSTR_W, ADDR_W)
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_next,
    input  logic               out_ready,
    output logic [CW-1:0]      count
);
    logic [ADDR_W-1:0] fetch_pc, pc_inc;
    logic [EW-1:0]     head;
    logic              push, pop, empty, full;

    assign pc_inc    = fetch_pc + ADDR_W'(PC_STEP);
    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    // Redirect hides the head so a stale instruction is never consumed.
    assign out_valid = !empty && !redirect;
    assign pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign imem_req  = !reset && !halt && !redirect && (!full || pop);
    assign push      = imem_req && imem_ready;
    assign imem_addr = fetch_pc;

    assign out_instr   = empty ? '0 : head[EW-1:ADDR_W];
    assign out_pc_next = empty ? '0 : head[ADDR_W-1:0];

    always_ff @(posedge clock) begin
        if (reset)         fetch_pc <= RESET_PC;
        else if (redirect) fetch_pc <= redirect_addr;
        else if (push)     fetch_pc <= pc_inc;
    end

    fetch_queue #(.W(EW), .DEPTH(DEPTH)) queue (
        .clock (clock),
        .reset (reset),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({imem_rdata, pc_inc}),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a queue-based reference model for fetch_unit.
module tb_fetch_unit;
    localparam logic [15:0] RPC [2] = '{16'h0000, 16'hFFFC};

    logic        clock = 0;
    logic        reset = 1, halt = 0, redirect = 0, imem_ready = 1, out_ready = 1;
    logic [15:0] redirect_addr = 0;
    logic [15:0] addr [2], rdata [2], instr [2], pc_next [2];
    logic        req [2], valid [2];
    logic [2:0]  cnt [2];

    int vectors = 0, errors = 0;
    bit run = 0;

    logic [15:0] mpc [2];
    logic [31:0] mq [2][$];

    always #5 clock = ~clock;

    assign rdata[0] = addr[0] ^ 16'hA5A5;
    assign rdata[1] = addr[1] ^ 16'hA5A5;

    fetch_unit #(.RESET_PC(16'h0000)) dut0 (
        .clock(clock), .reset(reset), .imem_addr(addr[0]), .imem_req(req[0]),
        .imem_ready(imem_ready), .imem_rdata(rdata[0]), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .out_valid(valid[0]),
        .out_instr(instr[0]), .out_pc_next(pc_next[0]), .out_ready(out_ready), .count(cnt[0])
    );

    fetch_unit #(.RESET_PC(16'hFFFC)) dut1 (
        .clock(clock), .reset(reset), .imem_addr(addr[1]), .imem_req(req[1]),
        .imem_ready(imem_ready), .imem_rdata(rdata[1]), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .out_valid(valid[1]),
        .out_instr(instr[1]), .out_pc_next(pc_next[1]), .out_ready(out_ready), .count(cnt[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: PC plus a list of {instr, next_pc} pairs; outputs follow from the occupancy rules.
    always @(negedge clock) begin
        int n;
        bit v, p, rq;
        logic [31:0] h;
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                n  = mq[k].size();
                v  = n != 0 && !redirect;
                p  = v && out_ready;
                rq = !reset && !halt && !redirect && (n < 4 || p);
                h  = n != 0 ? mq[k][0] : 32'h0;
                chk("imem_addr", k, 32'(addr[k]), 32'(mpc[k]));
                chk("imem_req", k, 32'(req[k]), 32'(rq));
                chk("out_valid", k, 32'(valid[k]), 32'(v));
                chk("out_instr", k, 32'(instr[k]), {16'h0, h[31:16]});
                chk("out_pc_next", k, 32'(pc_next[k]), {16'h0, h[15:0]});
                chk("count", k, 32'(cnt[k]), n);
                if (reset) begin
                    mpc[k] = RPC[k];
                    mq[k].delete();
                end else if (redirect) begin
                    mpc[k] = redirect_addr;
                    mq[k].delete();
                end else begin
                    if (p) void'(mq[k].pop_front());
                    if (rq && imem_ready) begin
                        mq[k].push_back({mpc[k] ^ 16'hA5A5, mpc[k] + 16'd2});
                        mpc[k] = mpc[k] + 16'd2;
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic rdy, input logic ordy, input logic h,
                        input logic rd, input logic [15:0] ra);
        @(posedge clock);
        #1;
        reset = r; imem_ready = rdy; out_ready = ordy; halt = h; redirect = rd; redirect_addr = ra;
        #3;
    endtask

    initial begin
        mpc[0] = RPC[0];
        mpc[1] = RPC[1];
        @(posedge clock);
        #1 run = 1;
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("rst_addr", 0, 32'(addr[0]), 32'h0000);
        chk("rst_req", 0, 32'(req[0]), 1);
        chk("rst_count", 0, 32'(cnt[0]), 0);
        chk("rst_addr", 1, 32'(addr[1]), 32'hFFFC);
        step(0, 1, 1, 0, 0, 0);
        chk("first_valid", 0, 32'(valid[0]), 1);
        chk("first_instr", 0, 32'(instr[0]), 32'hA5A5);
        chk("first_pc_next", 0, 32'(pc_next[0]), 32'h0002);
        chk("seq_addr", 0, 32'(addr[0]), 32'h0002);
        chk("seq_addr", 1, 32'(addr[1]), 32'hFFFE);
        step(0, 1, 1, 0, 0, 0);
        chk("wrap_addr", 1, 32'(addr[1]), 32'h0000);
        repeat (6) step(0, 1, 0, 0, 0, 0);
        chk("full_count", 0, 32'(cnt[0]), 4);
        chk("full_req", 0, 32'(req[0]), 0);
        repeat (6) step(0, 1, 1, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 16'h0100);
        step(0, 1, 1, 0, 0, 0);
        chk("redir_count", 0, 32'(cnt[0]), 0);
        chk("redir_valid", 0, 32'(valid[0]), 0);
        chk("redir_addr", 0, 32'(addr[0]), 32'h0100);
        step(0, 1, 1, 0, 0, 0);
        chk("redir_pc_next", 0, 32'(pc_next[0]), 32'h0102);
        step(0, 1, 0, 0, 0, 0);
        repeat (4) step(0, 1, 1, 1, 0, 0);
        chk("halt_valid", 0, 32'(valid[0]), 0);
        chk("halt_req", 0, 32'(req[0]), 0);
        step(0, 1, 1, 1, 1, 16'h0200);
        step(0, 1, 1, 1, 0, 0);
        chk("halt_redir_addr", 0, 32'(addr[0]), 32'h0200);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("stall_addr", 0, 32'(addr[0]), 32'h0202);
        step(0, 1, 1, 0, 0, 0);
        repeat (3000)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 16'($urandom) & 16'hFFFE);
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("midrst_count", 1, 32'(cnt[1]), 0);
        chk("midrst_addr", 1, 32'(addr[1]), 32'hFFFC);
        @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised successor to the fixed 16-bit fetch stage: PC register, sequential increment, and branch redirect. It adds a prefetch queue, a memory ready handshake, halt, and flush-on-redirect. It sits between the instruction memory and the decode stage, and replaces the PC/adder/mux group and the IF/ID hold/flush path. Decode consumes {instruction, next-PC} pairs through a valid/ready interface.

Parameters:
ADDR_W, 16, PC and address width
INSTR_W, 16, instruction width
PC_STEP, 2, byte increment per instruction
DEPTH, 4, prefetch queue entries (power of 2, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  ADDR_W  fetch address (= fetch_pc)
imem_req  out  1  fetch request this cycle
imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
imem_rdata  in  INSTR_W  instruction data, valid when imem_req & imem_ready
redirect  in  1  branch/jump taken; flush and reload PC
redirect_addr  in  ADDR_W  new fetch address
halt  in  1  level: stop issuing new fetches
out_valid  out  1  queue head valid to decode
out_instr  out  INSTR_W  head instruction
out_pc_next  out  ADDR_W  head address + PC_STEP
out_ready  in  1  decode accepts head (0 = hold)
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (synchronous, highest priority): fetch_pc=RESET_PC; queue empty; count=0; imem_req=0, out_valid=0, out_instr=0, out_pc_next=0 in the following cycle.
- pop = out_valid & out_ready. push = imem_req & imem_ready.
- imem_req = !reset & !halt & !redirect & (count<DEPTH | pop). Full with a simultaneous pop still permits a push.
- On push: enqueue {imem_rdata, fetch_pc+PC_STEP}; fetch_pc <= fetch_pc+PC_STEP.
- Arithmetic: all address arithmetic is modulo 2^ADDR_W. 0xFFFE+2 wraps to 0x0000 with no flag.
- Latency: an instruction accepted at cycle n appears at the head at cycle n+1 if the queue was empty. There is no combinational path from imem_rdata to out_*.
- out_valid = (count!=0) & !redirect. out_instr/out_pc_next show the head entry and are driven 0 when the queue is empty.
- Head is stable while out_valid & !out_ready (hold). Order is strictly FIFO.
- Redirect (priority over push/pop):
  - Queue cleared, count=0.
  - fetch_pc <= redirect_addr.
  - No push and no pop that cycle; the head is not consumed.
  - First fetch of redirect_addr is at the next cycle.
- Redirect and halt in the same cycle: PC reloaded, queue cleared, no fetch until halt drops.
- Halt: no new requests; the queue keeps draining to decode; fetch_pc is frozen. Deasserting halt resumes at the frozen fetch_pc.
- imem_ready=0 while requesting: keep imem_req=1 and imem_addr stable until accepted (or until redirect/halt removes the request).
- count = occupancy after the edge; pushes and pops in the same cycle leave it unchanged.

Decomposition:
- Package fetch_pkg: default width constants, RESET_PC default, and a queue-entry struct/width helper (INSTR_W+ADDR_W).
- Sub-module fetch_queue: synchronous FIFO, DEPTH entries, with push/pop/clear, read/write pointers, count, and combinational head read.
- fetch_unit holds the PC register, request logic, and priority ordering.

Test Plan:
- Reset then imem_ready=1, out_ready=1, memory returns addr^16'hA5A5 -> imem_addr 0x0000, 0x0002, 0x0004...; at cycle 1 out_instr=0xA5A5, out_pc_next=0x0002; one instruction per cycle.
- out_ready=0 for 6 cycles with DEPTH=4 -> count saturates at 4, imem_req drops, head stays at pc_next=0x0002. Raising out_ready -> 4 in-order pops, no loss or duplication.
- Redirect to 0x0100 with 3 entries queued -> next cycle count=0, out_valid=0, imem_addr=0x0100. The first instruction out has out_pc_next=0x0102.
- Halt with 2 entries queued -> both drain, then out_valid=0 and imem_addr frozen. Release halt -> fetch resumes at the frozen address.
- imem_ready toggling 1,0,0,1 -> address held during 0s; no push during 0s.
- RESET_PC=0xFFFC, ADDR_W=16 -> addresses 0xFFFC, 0xFFFE, 0x0000. Reset asserted mid-stream -> next cycle count=0, imem_addr=0xFFFC.
